datactrl: RTL and testbench

Responder side of the load-buffer / data-controller protocol. The block serves load requests from the load buffer and committed store requests from the reorder buffer. It serialises each request into byte-wide accesses on the single-port RAM bus, and returns assembled, sign/zero-extended load data with a one-cycle completion pulse. It sits between lbuffer/ROB and the memory arbiter.

---
 rtl/datactrl.sv | 163 ++++++++++++++++
 tb/tb_datactrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/datactrl.sv
// Data controller: serialises load-buffer loads and ROB stores into byte accesses on a
// single-port RAM bus, returning sign/zero-extended load data with a one-cycle pulse.
module datactrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,

  input  logic                  lbuffer_datactrl_en_in,
  input  logic [ADDR_WIDTH-1:0] lbuffer_datactrl_addr_in,
  input  logic [2:0]            lbuffer_datactrl_width_in,
  input  logic                  lbuffer_datactrl_sgn_in,
  output logic                  datactrl_lbuffer_en_out,
  output logic [DATA_WIDTH-1:0] datactrl_lbuffer_data_out,

  input  logic                  rob_datactrl_en_in,
  input  logic [ADDR_WIDTH-1:0] rob_datactrl_addr_in,
  input  logic [2:0]            rob_datactrl_width_in,
  input  logic [DATA_WIDTH-1:0] rob_datactrl_data_in,
  output logic                  datactrl_rob_done_out,
  input  logic                  rob_datactrl_rst_in,

  input  logic [7:0]            mem_din_in,
  output logic [7:0]            mem_dout_out,
  output logic [ADDR_WIDTH-1:0] mem_a_out,
  output logic                  mem_wr_out
);

  localparam int unsigned ByteExt = DATA_WIDTH - 8;
  localparam int unsigned HalfExt = DATA_WIDTH - 16;

  typedef enum logic [1:0] {StIdle, StLoad, StStore, StDone} state_e;

  state_e                state_q;
  logic                  is_load_q;
  logic [2:0]            cnt_q;
  logic [2:0]            nbytes_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  sgn_q;
  logic [DATA_WIDTH-1:0] sdata_q;
  logic [DATA_WIDTH-1:0] assembly_q;

  logic [2:0]            cnt_nxt;
  logic                  last_byte;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [7:0]            store_byte_nxt;
  logic [DATA_WIDTH-1:0] load_full;
  logic [DATA_WIDTH-1:0] load_result;

  // Unknown width encodings fall back to a full word.
  function automatic logic [2:0] width_to_n(input logic [2:0] w);
    case (w)
      3'b001:  return 3'd1;
      3'b010:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  always_comb begin
    cnt_nxt        = cnt_q + 3'd1;
    last_byte      = (cnt_nxt >= nbytes_q);
    addr_nxt       = addr_q + ADDR_WIDTH'(cnt_nxt);
    store_byte_nxt = sdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
    // The final byte bypasses the assembly register straight from the RAM.
    load_full = assembly_q;
    load_full[{cnt_q[1:0], 3'b000} +: 8] = mem_din_in;
    case (nbytes_q)
      3'd1:    load_result = {{ByteExt{sgn_q & load_full[7]}}, load_full[7:0]};
      3'd2:    load_result = {{HalfExt{sgn_q & load_full[15]}}, load_full[15:0]};
      default: load_result = load_full;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q                   <= StIdle;
      is_load_q                 <= 1'b0;
      cnt_q                     <= '0;
      nbytes_q                  <= '0;
      addr_q                    <= '0;
      sgn_q                     <= 1'b0;
      sdata_q                   <= '0;
      assembly_q                <= '0;
      datactrl_lbuffer_en_out   <= 1'b0;
      datactrl_lbuffer_data_out <= '0;
      datactrl_rob_done_out     <= 1'b0;
      mem_dout_out              <= '0;
      mem_a_out                 <= '0;
      mem_wr_out                <= 1'b0;
    end else if (rdy_in) begin
      datactrl_lbuffer_en_out <= 1'b0;
      datactrl_rob_done_out   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Committed stores win arbitration and ignore flush.
          if (rob_datactrl_en_in) begin
            state_q      <= StStore;
            is_load_q    <= 1'b0;
            cnt_q        <= '0;
            nbytes_q     <= width_to_n(rob_datactrl_width_in);
            addr_q       <= rob_datactrl_addr_in;
            sdata_q      <= rob_datactrl_data_in;
            mem_a_out    <= rob_datactrl_addr_in;
            mem_dout_out <= rob_datactrl_data_in[7:0];
            mem_wr_out   <= 1'b1;
          end else if (lbuffer_datactrl_en_in && !rob_datactrl_rst_in) begin
            state_q    <= StLoad;
            is_load_q  <= 1'b1;
            cnt_q      <= '0;
            nbytes_q   <= width_to_n(lbuffer_datactrl_width_in);
            addr_q     <= lbuffer_datactrl_addr_in;
            sgn_q      <= lbuffer_datactrl_sgn_in;
            assembly_q <= '0;
            mem_a_out  <= lbuffer_datactrl_addr_in;
          end
        end
        StLoad: begin
          if (rob_datactrl_rst_in) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            assembly_q <= '0;
            mem_a_out  <= '0;
          end else if (last_byte) begin
            state_q                   <= StDone;
            cnt_q                     <= '0;
            assembly_q                <= load_full;
            datactrl_lbuffer_data_out <= load_result;
            datactrl_lbuffer_en_out   <= 1'b1;
            mem_a_out                 <= '0;
          end else begin
            assembly_q <= load_full;
            cnt_q      <= cnt_nxt;
            mem_a_out  <= addr_nxt;
          end
        end
        StStore: begin
          if (last_byte) begin
            state_q               <= StDone;
            cnt_q                 <= '0;
            datactrl_rob_done_out <= 1'b1;
            mem_a_out             <= '0;
            mem_dout_out          <= '0;
            mem_wr_out            <= 1'b0;
          end else begin
            cnt_q        <= cnt_nxt;
            mem_a_out    <= addr_nxt;
            mem_dout_out <= store_byte_nxt;
          end
        end
        StDone: begin
          state_q <= StIdle;
          if (rob_datactrl_rst_in && is_load_q) begin
            assembly_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_datactrl.sv
// Directed bench for datactrl: byte-addressed RAM model driven from mem_a_out, write log,
// and hand-computed expectations for loads, stores, arbitration, flush, stall and reset.
module tb_datactrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        lb_en = 1'b0;
  logic [31:0] lb_addr = '0;
  logic [2:0]  lb_width = '0;
  logic        lb_sgn = 1'b0;
  logic        lb_done;
  logic [31:0] lb_data;
  logic        rob_en = 1'b0;
  logic [31:0] rob_addr = '0;
  logic [2:0]  rob_width = '0;
  logic [31:0] rob_data = '0;
  logic        rob_done;
  logic        flush = 1'b0;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  logic [7:0]  ram [256];
  logic [39:0] wr_log [$];
  logic [31:0] a_seen [32];
  int          n_total = 0;
  int          n_bad = 0;
  int          lb_pulses = 0;

  always #5 clk_in = ~clk_in;

  assign mem_din = ram[mem_a[7:0]];

  datactrl dut (
    .clk_in                    (clk_in),
    .rst_in                    (rst_in),
    .rdy_in                    (rdy_in),
    .lbuffer_datactrl_en_in    (lb_en),
    .lbuffer_datactrl_addr_in  (lb_addr),
    .lbuffer_datactrl_width_in (lb_width),
    .lbuffer_datactrl_sgn_in   (lb_sgn),
    .datactrl_lbuffer_en_out   (lb_done),
    .datactrl_lbuffer_data_out (lb_data),
    .rob_datactrl_en_in        (rob_en),
    .rob_datactrl_addr_in      (rob_addr),
    .rob_datactrl_width_in     (rob_width),
    .rob_datactrl_data_in      (rob_data),
    .datactrl_rob_done_out     (rob_done),
    .rob_datactrl_rst_in       (flush),
    .mem_din_in                (mem_din),
    .mem_dout_out              (mem_dout),
    .mem_a_out                 (mem_a),
    .mem_wr_out                (mem_wr)
  );

  always @(negedge clk_in) begin
    if (mem_wr) wr_log.push_back({mem_a, mem_dout});
    if (lb_done) lb_pulses++;
  end

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Issues a load and waits for its pulse; optionally drops rdy for 3 edges after edge stall_at.
  task automatic run_load(input logic [31:0] addr, input logic [2:0] w, input logic s,
                          input int stall_at, output logic [31:0] data, output int lat);
    lb_addr = addr; lb_width = w; lb_sgn = s; lb_en = 1'b1;
    lat = 0; data = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      a_seen[k] = mem_a;
      if (lb_done) begin
        lat = k;
        data = lb_data;
        break;
      end
      if (stall_at != 0 && k == stall_at) rdy_in = 1'b0;
      if (stall_at != 0 && k == stall_at + 3) rdy_in = 1'b1;
    end
    lb_en = 1'b0;
    rdy_in = 1'b1;
    if (lat == 0) check_eq("load timeout", 40'd0, 40'd1);
    tick();
    check_eq("load pulse width", {39'd0, lb_done}, 40'd0);
  endtask

  task automatic run_store(input logic [31:0] addr, input logic [2:0] w, input logic [31:0] d,
                           output int lat);
    wr_log.delete();
    rob_addr = addr; rob_width = w; rob_data = d; rob_en = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (rob_done) begin
        lat = k;
        check_eq("store wr low at done", {39'd0, mem_wr}, 40'd0);
        break;
      end
    end
    rob_en = 1'b0;
    if (lat == 0) check_eq("store timeout", 40'd0, 40'd1);
    tick();
    check_eq("store done width", {39'd0, rob_done}, 40'd0);
  endtask

  initial begin
    logic [31:0] d;
    int          lat;
    int          k_done;
    int          k_load;
    int          pulses_before;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;

    #12;
    check_eq("reset lb_en", {39'd0, lb_done}, 40'd0);
    check_eq("reset lb_data", {8'd0, lb_data}, 40'd0);
    check_eq("reset done", {39'd0, rob_done}, 40'd0);
    check_eq("reset mem_a", {8'd0, mem_a}, 40'd0);
    check_eq("reset mem_wr", {39'd0, mem_wr}, 40'd0);
    check_eq("reset mem_dout", {32'd0, mem_dout}, 40'd0);
    #10 rst_in = 1'b1;
    tick();

    // Byte loads, signed and unsigned
    ram[8'h00] = 8'h80;
    run_load(32'h0000_1000, 3'b001, 1'b1, 0, d, lat);
    check_eq("lb data", {8'd0, d}, {8'd0, 32'hFFFF_FF80});
    check_eq("lb latency", 40'(lat), 40'd2);
    check_eq("lb addr", {8'd0, a_seen[1]}, {8'd0, 32'h0000_1000});
    check_eq("lb addr after", {8'd0, a_seen[2]}, 40'd0);
    run_load(32'h0000_1000, 3'b001, 1'b0, 0, d, lat);
    check_eq("lbu data", {8'd0, d}, {8'd0, 32'h0000_0080});

    // Half loads
    ram[8'h02] = 8'h34; ram[8'h03] = 8'h12;
    run_load(32'h0000_2002, 3'b010, 1'b0, 0, d, lat);
    check_eq("lhu data", {8'd0, d}, {8'd0, 32'h0000_1234});
    check_eq("lhu latency", 40'(lat), 40'd3);
    ram[8'h03] = 8'h92;
    run_load(32'h0000_2002, 3'b010, 1'b1, 0, d, lat);
    check_eq("lh data", {8'd0, d}, {8'd0, 32'hFFFF_9234});

    // Word load
    ram[8'h04] = 8'h78; ram[8'h05] = 8'h56; ram[8'h06] = 8'h34; ram[8'h07] = 8'h12;
    run_load(32'h0000_2004, 3'b100, 1'b1, 0, d, lat);
    check_eq("lw data", {8'd0, d}, {8'd0, 32'h1234_5678});
    check_eq("lw latency", 40'(lat), 40'd5);
    check_eq("lw addr3", {8'd0, a_seen[4]}, {8'd0, 32'h0000_2007});

    // Word store
    run_store(32'h0000_3000, 3'b100, 32'hDEAD_BEEF, lat);
    check_eq("sw latency", 40'(lat), 40'd5);
    check_eq("sw nwrites", 40'(wr_log.size()), 40'd4);
    if (wr_log.size() == 4) begin
      check_eq("sw byte0", wr_log[0], {32'h0000_3000, 8'hEF});
      check_eq("sw byte1", wr_log[1], {32'h0000_3001, 8'hBE});
      check_eq("sw byte2", wr_log[2], {32'h0000_3002, 8'hAD});
      check_eq("sw byte3", wr_log[3], {32'h0000_3003, 8'hDE});
    end

    // Store and load requested together: store first, load at the earliest next slot
    wr_log.delete();
    ram[8'h00] = 8'h7F;
    rob_addr = 32'h0000_4000; rob_width = 3'b001; rob_data = 32'h0000_0055; rob_en = 1'b1;
    lb_addr = 32'h0000_1000; lb_width = 3'b001; lb_sgn = 1'b1; lb_en = 1'b1;
    k_done = 0; k_load = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (rob_done) begin k_done = k; rob_en = 1'b0; end
      if (lb_done) begin k_load = k; d = lb_data; lb_en = 1'b0; break; end
    end
    rob_en = 1'b0; lb_en = 1'b0;
    tick();
    check_eq("both store lat", 40'(k_done), 40'd2);
    check_eq("both load lat", 40'(k_load), 40'd5);
    check_eq("both load data", {8'd0, d}, {8'd0, 32'h0000_007F});
    check_eq("both nwrites", 40'(wr_log.size()), 40'd1);
    if (wr_log.size() == 1) check_eq("both write", wr_log[0], {32'h0000_4000, 8'h55});

    // Flush after two bytes of a word load
    pulses_before = lb_pulses;
    lb_addr = 32'h0000_2004; lb_width = 3'b100; lb_sgn = 1'b0; lb_en = 1'b1;
    tick(); tick(); tick();
    flush = 1'b1; lb_en = 1'b0;
    tick();
    flush = 1'b0;
    check_eq("flush mem_a", {8'd0, mem_a}, 40'd0);
    check_eq("flush no pulse", {39'd0, lb_done}, 40'd0);
    repeat (4) tick();
    check_eq("flush pulse count", 40'(lb_pulses), 40'(pulses_before));
    check_eq("flush data held", {8'd0, lb_data}, {8'd0, 32'h0000_007F});
    ram[8'h00] = 8'hC3;
    run_load(32'h0000_1000, 3'b001, 1'b0, 0, d, lat);
    check_eq("post flush lb", {8'd0, d}, {8'd0, 32'h0000_00C3});
    check_eq("post flush lat", 40'(lat), 40'd2);

    // Flush during a byte store does not abort it
    wr_log.delete();
    rob_addr = 32'h0000_5000; rob_width = 3'b001; rob_data = 32'h0000_00A5; rob_en = 1'b1;
    k_done = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) flush = 1'b1;
      if (rob_done) begin k_done = k; break; end
    end
    flush = 1'b0; rob_en = 1'b0;
    tick();
    check_eq("flush sb lat", 40'(k_done), 40'd2);
    check_eq("flush sb nwrites", 40'(wr_log.size()), 40'd1);
    if (wr_log.size() == 1) check_eq("flush sb write", wr_log[0], {32'h0000_5000, 8'hA5});

    // Stall mid word load
    run_load(32'h0000_2004, 3'b100, 1'b0, 2, d, lat);
    check_eq("stall lw data", {8'd0, d}, {8'd0, 32'h1234_5678});
    check_eq("stall lw lat", 40'(lat), 40'd8);
    check_eq("stall addr held", {8'd0, a_seen[4]}, {8'd0, 32'h0000_2005});

    // Address wrap-around
    ram[8'hFF] = 8'hAA; ram[8'h00] = 8'hBB; ram[8'h01] = 8'hCC; ram[8'h02] = 8'hDD;
    run_load(32'hFFFF_FFFF, 3'b100, 1'b0, 0, d, lat);
    check_eq("wrap data", {8'd0, d}, {8'd0, 32'hDDCC_BBAA});
    check_eq("wrap a0", {8'd0, a_seen[1]}, {8'd0, 32'hFFFF_FFFF});
    check_eq("wrap a1", {8'd0, a_seen[2]}, 40'd0);
    check_eq("wrap a2", {8'd0, a_seen[3]}, {8'd0, 32'h0000_0001});
    check_eq("wrap a3", {8'd0, a_seen[4]}, {8'd0, 32'h0000_0002});

    // Asynchronous reset in the middle of a store
    rob_addr = 32'h0000_6000; rob_width = 3'b100; rob_data = 32'h1122_3344; rob_en = 1'b1;
    tick(); tick();
    check_eq("pre reset wr", {39'd0, mem_wr}, 40'd1);
    #2 rst_in = 1'b0;
    #1;
    check_eq("async rst mem_a", {8'd0, mem_a}, 40'd0);
    check_eq("async rst wr", {39'd0, mem_wr}, 40'd0);
    check_eq("async rst dout", {32'd0, mem_dout}, 40'd0);
    check_eq("async rst lb_data", {8'd0, lb_data}, 40'd0);
    check_eq("async rst done", {39'd0, rob_done}, 40'd0);
    rob_en = 1'b0;
    #1 rst_in = 1'b1;
    tick();
    ram[8'h00] = 8'h01;
    run_load(32'h0000_1000, 3'b001, 1'b1, 0, d, lat);
    check_eq("post reset lb", {8'd0, d}, {8'd0, 32'h0000_0001});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
